// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-stage branch predictor: datapath width,
// default table depth and the 2-bit confidence counter encodings.
package branch_predictor_pkg;

  localparam int BP_XLEN    = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_CNT_W   = 32;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,  // strongly not taken
    BP_WNT = 2'b01,  // weakly not taken (reset value)
    BP_WT  = 2'b10,  // weakly taken (fresh allocation)
    BP_ST  = 2'b11   // strongly taken
  } ctr_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, decode-stage training, control and statistics signals of
// the predictor. The pipeline side is the master, the predictor the slave.
interface branch_predictor_if
  import branch_predictor_pkg::*;
#(
  parameter int XLEN = BP_XLEN
);
  // fetch lookup
  logic [XLEN-1:0]     pcF;
  logic                pred_takenF;
  logic [XLEN-1:0]     pred_targF;
  // decode-stage resolution
  logic                upd_valid;
  logic [XLEN-1:0]     upd_pc;
  logic                upd_taken;
  logic [XLEN-1:0]     upd_target;
  logic                upd_pred_taken;
  logic [XLEN-1:0]     upd_pred_targ;
  logic                mispredictD;
  logic [XLEN-1:0]     redirect_pcD;
  // control and statistics
  logic                bp_flush;
  logic                cnt_clear;
  logic [BP_CNT_W-1:0] branch_cnt;
  logic [BP_CNT_W-1:0] mispred_cnt;

  modport master (
    output pcF, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
           upd_pred_targ, bp_flush, cnt_clear,
    input  pred_takenF, pred_targF, mispredictD, redirect_pcD, branch_cnt,
           mispred_cnt
  );

  modport slave (
    input  pcF, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
           upd_pred_targ, bp_flush, cnt_clear,
    output pred_takenF, pred_targF, mispredictD, redirect_pcD, branch_cnt,
           mispred_cnt
  );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating confidence counter next-state: step toward taken or
// not-taken, sticking at the strong ends.
module branch_predictor_sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // saturating increment on taken, decrement on not taken
  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != BP_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != BP_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters. Zero-latency
// lookup of pcF, training from decode-stage resolution, mispredict
// detection with redirect PC, and branch/mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN    = BP_XLEN,
  parameter int ENTRIES = BP_ENTRIES
)(
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0]            valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic [ENTRIES-1:0][XLEN-1:0]  targ_q;
  logic [ENTRIES-1:0][1:0]       ctr_q;
  logic [BP_CNT_W-1:0]           branch_q;
  logic [BP_CNT_W-1:0]           mispred_q;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  logic [1:0]       ctr_next;

  // fetch lookup: pure combinational read of the current table
  assign f_idx = bp.pcF[IDX_W+1:2];
  assign f_tag = bp.pcF[XLEN-1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign bp.pred_takenF = f_hit & ctr_q[f_idx][1];
  assign bp.pred_targF  = bp.pred_takenF ? targ_q[f_idx] : bp.pcF + XLEN'(4);

  // resolution: correct next PC and mispredict against what travelled along
  assign u_idx = bp.upd_pc[IDX_W+1:2];
  assign u_tag = bp.upd_pc[XLEN-1:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign bp.redirect_pcD = bp.upd_taken ? bp.upd_target : bp.upd_pc + XLEN'(4);
  assign bp.mispredictD  = bp.upd_valid &
                           ((bp.upd_taken != bp.upd_pred_taken) |
                            (bp.redirect_pcD != bp.upd_pred_targ));

  branch_predictor_sat_counter2 u_ctr (
    .ctr      (ctr_q[u_idx]),
    .taken    (bp.upd_taken),
    .ctr_next (ctr_next)
  );

  // table write: flush beats training; a not-taken miss leaves the table alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q   <= '0;
      targ_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BP_WNT;
    end else if (bp.bp_flush) begin
      valid_q <= '0;
    end else if (bp.upd_valid) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_next;
        if (bp.upd_taken) targ_q[u_idx] <= bp.upd_target;
      end else if (bp.upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        targ_q[u_idx]  <= bp.upd_target;
        ctr_q[u_idx]   <= BP_WT;
      end
    end
  end

  // statistics: clear wins over a same-cycle increment; both wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_q  <= '0;
      mispred_q <= '0;
    end else if (bp.cnt_clear) begin
      branch_q  <= '0;
      mispred_q <= '0;
    end else begin
      if (bp.upd_valid)   branch_q  <= branch_q + BP_CNT_W'(1);
      if (bp.mispredictD) mispred_q <= mispred_q + BP_CNT_W'(1);
    end
  end

  assign bp.branch_cnt  = branch_q;
  assign bp.mispred_cnt = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a driver issues one cycle of
// stimulus, predicts the response from a table model and queues it; a
// monitor pops and compares on every falling edge.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(XLEN)) bp();

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  typedef struct {
    logic        pt;
    logic [31:0] pg;
    logic        mp;
    logic [31:0] rd;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model: per-slot owner PC, target and confidence 0..3
  bit          mval[ENTRIES];
  logic [31:0] mpc [ENTRIES];
  logic [31:0] mtgt[ENTRIES];
  int          mctr[ENTRIES];
  logic [31:0] mbc, mmc;

  function automatic int midx(logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit mhit(logic [31:0] pc);
    int i = midx(pc);
    return mval[i] && (mpc[i] / (4 * ENTRIES) == pc / (4 * ENTRIES));
  endfunction

  function automatic void model_pred(input logic [31:0] pc, output logic t, output logic [31:0] g);
    int i = midx(pc);
    t = mhit(pc) && (mctr[i] >= 2);
    g = t ? mtgt[i] : pc + 32'd4;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      mval[i] = 1'b0;
      mctr[i] = 1;
    end
    mbc = 0;
    mmc = 0;
  endfunction

  function automatic void model_step(logic [31:0] upc, bit uv, bit ut, logic [31:0] utg,
                                     bit mp, bit fl, bit clr);
    int i = midx(upc);
    if (fl) begin
      for (int k = 0; k < ENTRIES; k++) mval[k] = 1'b0;
    end else if (uv) begin
      if (mhit(upc)) begin
        mctr[i] = ut ? ((mctr[i] < 3) ? mctr[i] + 1 : 3) : ((mctr[i] > 0) ? mctr[i] - 1 : 0);
        if (ut) mtgt[i] = utg;
      end else if (ut) begin
        mval[i] = 1'b1;
        mpc[i]  = upc;
        mtgt[i] = utg;
        mctr[i] = 2;
      end
    end
    if (clr) begin
      mbc = 0;
      mmc = 0;
    end else begin
      mbc = mbc + 32'(uv);
      mmc = mmc + 32'(mp);
    end
  endfunction

  // one stimulus cycle: drive after the edge, queue the expected response
  task automatic cyc(input logic [31:0] pc, input bit uv, input logic [31:0] upc, input bit ut,
                     input logic [31:0] utg, input bit upt, input logic [31:0] uptg,
                     input bit fl = 0, input bit clr = 0, input bit rstn = 1, input bit preload = 0);
    exp_t        e;
    logic [31:0] rd;
    bit          mp;
    @(posedge clk);
    #1;
    rst_n             = rstn;
    bp.pcF            = pc;
    bp.upd_valid      = uv;
    bp.upd_pc         = upc;
    bp.upd_taken      = ut;
    bp.upd_target     = utg;
    bp.upd_pred_taken = upt;
    bp.upd_pred_targ  = uptg;
    bp.bp_flush       = fl;
    bp.cnt_clear      = clr;
    if (!rstn) model_reset();
    if (preload) begin
      force dut.mispred_q = 32'hFFFF_FFFF;
      mmc = 32'hFFFF_FFFF;
    end
    rd = ut ? utg : upc + 32'd4;
    mp = uv && ((ut != upt) || (rd != uptg));
    model_pred(pc, e.pt, e.pg);
    e.mp = mp;
    e.rd = rd;
    e.bc = mbc;
    e.mc = mmc;
    q.push_back(e);
    if (rstn) model_step(upc, uv, ut, utg, mp, fl, clr);
    if (preload) begin
      #5;
      release dut.mispred_q;
    end
  endtask

  task automatic idle(input logic [31:0] pc);
    cyc(pc, 0, 32'h0, 0, 32'h0, 0, 32'h4);
  endtask

  // training update that carries the model's own prediction for upc
  task automatic train(input logic [31:0] pc, input logic [31:0] upc, input bit ut, input logic [31:0] utg,
                       input bit fl = 0, input bit clr = 0);
    logic        t;
    logic [31:0] g;
    model_pred(upc, t, g);
    cyc(pc, 1, upc, ut, utg, t, g, fl, clr);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: the outputs are always presented, so compare every queued cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pred_takenF",  32'(bp.pred_takenF), 32'(e.pt));
        chk("pred_targF",   bp.pred_targF,       e.pg);
        chk("mispredictD",  32'(bp.mispredictD), 32'(e.mp));
        chk("redirect_pcD", bp.redirect_pcD,     e.rd);
        chk("branch_cnt",   bp.branch_cnt,       e.bc);
        chk("mispred_cnt",  bp.mispred_cnt,      e.mc);
      end
    end
  end

  function automatic logic [31:0] rpc();
    return 32'h1000 + ($urandom_range(0, 2) << (IDX_W + 2)) + ($urandom_range(0, ENTRIES - 1) << 2)
           + $urandom_range(0, 3);
  endfunction

  initial begin
    logic [31:0] pc, upc, utg, g;
    logic        t;
    bit          uv, ut, fl, clr;
    model_reset();
    bp.pcF = 32'h100; bp.upd_valid = 0; bp.upd_pc = 0; bp.upd_taken = 0; bp.upd_target = 0;
    bp.upd_pred_taken = 0; bp.upd_pred_targ = 0; bp.bp_flush = 0; bp.cnt_clear = 0;

    // reset, then a quiet lookup
    cyc(32'h100, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0);
    cyc(32'h100, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0);
    idle(32'h100);

    // first taken branch mispredicts and allocates
    cyc(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
    idle(32'h100);

    // not-taken training saturates the counter down
    repeat (3) train(32'h100, 32'h100, 0, 32'h0);
    idle(32'h100);

    // aliasing: same index, different tag replaces the entry
    train(32'h100, 32'h100, 1, 32'h180);
    train(32'h140, 32'h140, 1, 32'h500);
    idle(32'h100);
    idle(32'h140);

    // lookup sees pre-update contents; flush beats a same-cycle update
    train(32'h200, 32'h200, 1, 32'h600);
    idle(32'h200);
    train(32'h140, 32'h140, 1, 32'h540, 1, 0);
    idle(32'h200);
    idle(32'h140);

    // mispredict counter wrap, then clear against a same-cycle increment
    cyc(32'h100, 1, 32'h300, 1, 32'h700, 0, 32'h304, 0, 0, 1, 1);
    idle(32'h300);
    cyc(32'h300, 1, 32'h300, 1, 32'h700, 0, 32'h304, 0, 1);
    idle(32'h300);

    // reset asserted mid-update drops the write and clears counters at once
    train(32'h3c0, 32'h3c0, 1, 32'h900);
    cyc(32'h3c0, 1, 32'h3c4, 1, 32'h900, 0, 32'h3c8, 0, 0, 0);
    idle(32'h3c4);
    idle(32'h3c0);

    // randomized traffic over a small aliasing PC space
    repeat (400) begin
      pc  = rpc();
      upc = rpc();
      uv  = 1'($urandom_range(0, 1));
      ut  = 1'($urandom_range(0, 1));
      utg = $urandom & 32'hFFFF_FFFC;
      fl  = ($urandom_range(0, 29) == 0);
      clr = ($urandom_range(0, 29) == 0);
      model_pred(upc, t, g);
      if ($urandom_range(0, 3) == 0) begin
        t = 1'($urandom_range(0, 1));
        g = $urandom_range(0, 1) ? upc + 32'd4 : $urandom;
      end
      cyc(pc, uv, upc, ut, utg, t, g, fl, clr);
    end

    repeat (3) @(posedge clk);
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
